// File: rtl/m_inputmux_nch.sv
// N-channel I/O input mux: per-channel fixed-latency or handshake FSM with timeout,
// capture register rDee and the final Di merge stage toward the core.
module m_inputmux_nch #(
  parameter int                NCH        = 4,
  parameter int                IWIDTH     = 32,
  parameter int                CHSEL_LSB  = 27,
  parameter logic [NCH*4-1:0]  WAITSTATES = {(NCH*4){1'b0}},
  parameter logic [NCH-1:0]    ACKMODE    = {NCH{1'b0}},
  parameter int                TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             DAT_O,
  input  logic [NCH*IWIDTH-1:0]   DAT_I,
  input  logic [NCH-1:0]          ch_ack_i,
  input  logic [31:0]             ADR_O,
  input  logic                    sra_msb,
  input  logic                    sa00,
  input  logic                    STB_O,
  input  logic                    qACK,
  input  logic                    corerunning,
  output logic [31:0]             Di,
  output logic [31:0]             rDee,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic                    busy
);

  localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] chq_r, chq_s, ch_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [31:0]   rdee_r, rdee_s, shadr_s;
  logic          err_s, ch_ok_s;
  logic          ack_r, err_r, busy_r, sa00mod_r;

  function automatic logic [3:0] ws_of(input logic [CW-1:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      if (c == CW'(i)) r = WAITSTATES[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic bit_of(input logic [NCH-1:0] v, input logic [CW-1:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (c == CW'(i)) r = v[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] dat_of(input logic [NCH*IWIDTH-1:0] d, input logic [CW-1:0] c);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      if (c == CW'(i)) r = 32'(d[i*IWIDTH +: IWIDTH]);
    end
    return r;
  endfunction

  assign ch_s    = ADR_O[CHSEL_LSB +: CW];
  assign ch_ok_s = (32'(ch_s) < NCH);
  assign shadr_s = {sra_msb, ADR_O[31:1]};

  // Next-state, counter and capture decisions; every write to rdee is gated by corerunning
  always_comb begin
    state_s = state_r;
    chq_s   = chq_r;
    cnt_s   = cnt_r;
    rdee_s  = rdee_r;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (STB_O && corerunning) begin
          chq_s = ch_s;
          if (!ch_ok_s) begin
            state_s = ST_ACK;
            err_s   = 1'b1;
            rdee_s  = 32'd0;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = bit_of(ACKMODE, ch_s) ? 8'd0 : {4'd0, ws_of(ch_s)};
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!corerunning) begin
          state_s = ST_IDLE;
        end else if (bit_of(ACKMODE, chq_r)) begin
          // a ready on the timeout cycle still wins over the timeout
          if (bit_of(ch_ack_i, chq_r)) begin
            rdee_s  = dat_of(DAT_I, chq_r);
            state_s = ST_ACK;
          end else if (cnt_r == TO_LAST) begin
            rdee_s  = 32'hFFFF_FFFF;
            err_s   = 1'b1;
            state_s = ST_ACK;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else begin
          if (cnt_r == 8'd0) begin
            rdee_s  = dat_of(DAT_I, chq_r);
            state_s = ST_ACK;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, capture register, registered status outputs and the Di mux select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      chq_r     <= {CW{1'b0}};
      cnt_r     <= 8'd0;
      rdee_r    <= 32'd0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      sa00mod_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      chq_r     <= chq_s;
      cnt_r     <= cnt_s;
      rdee_r    <= rdee_s;
      ack_r     <= (state_s == ST_ACK);
      err_r     <= (state_s == ST_ACK) & err_s;
      busy_r    <= (state_s != ST_IDLE);
      sa00mod_r <= ~(qACK | ack_r | sa00 | ~corerunning);
    end
  end

  assign Di    = sa00mod_r ? DAT_O : ((DAT_O & rdee_r) | (~DAT_O & shadr_s));
  assign rDee  = rdee_r;
  assign ACK_O = ack_r;
  assign ERR_O = err_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_m_inputmux_nch.sv
// Scoreboarded random bench for m_inputmux_nch: a 4-channel 32-bit instance carries the
// random traffic, a 3-channel 8-bit instance covers bad-channel, zero-wait and abort cases.
module tb_m_inputmux_nch;

  localparam int TMO = 15;
  localparam int WS_TAB[4] = '{15, 3, 0, 0};

  typedef struct {
    int          cyc;
    logic [31:0] rdee;
    logic        err;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  DAT_O, ADR_O;
  logic [127:0] DAT_I;
  logic [3:0]   ch_ack_i;
  logic         sra_msb, sa00, STB_O, qACK, corerunning;
  logic [31:0]  Di, rDee;
  logic         ACK_O, ERR_O, busy;
  logic         stb3;
  logic [23:0]  dat3;
  logic [31:0]  di3, rdee3;
  logic         ack3, err3, busy3;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [31:0] last_rdee;
  logic [31:0] d3;

  m_inputmux_nch #(
    .NCH(4), .IWIDTH(32), .CHSEL_LSB(27),
    .WAITSTATES(16'h003F), .ACKMODE(4'b1100), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .DAT_O(DAT_O), .DAT_I(DAT_I), .ch_ack_i(ch_ack_i),
    .ADR_O(ADR_O), .sra_msb(sra_msb), .sa00(sa00), .STB_O(STB_O), .qACK(qACK),
    .corerunning(corerunning), .Di(Di), .rDee(rDee), .ACK_O(ACK_O), .ERR_O(ERR_O), .busy(busy)
  );

  m_inputmux_nch #(
    .NCH(3), .IWIDTH(8), .CHSEL_LSB(27),
    .WAITSTATES(12'h0A0), .ACKMODE(3'b000), .TIMEOUT(TMO)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .DAT_O(DAT_O), .DAT_I(dat3), .ch_ack_i(ch_ack_i[2:0]),
    .ADR_O(ADR_O), .sra_msb(sra_msb), .sa00(sa00), .STB_O(stb3), .qACK(qACK),
    .corerunning(corerunning), .Di(di3), .rDee(rdee3), .ACK_O(ack3), .ERR_O(err3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] di_ref(input logic mod, input logic [31:0] dato,
                                         input logic [31:0] rd, input logic [31:0] adr,
                                         input logic msb);
    logic [31:0] sh;
    sh = {msb, adr[31:1]};
    return mod ? dato : ((dato & rd) | (~dato & sh));
  endfunction

  // Monitor: every ACK_O pulse pops one expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && ACK_O) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'(ACK_O), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("ack_rdee", rDee, e.rdee);
        chk("ack_err", 32'(ERR_O), 32'(e.err));
      end
    end else if (rst_n && ERR_O) begin
      chk("err_without_ack", 32'(ERR_O), 32'd0);
    end
  end

  // One transfer on the main instance. ack_at: edge offset after the STB sample edge at
  // which the selected ready is first seen high (0 = never). ACK_O is visible right after
  // edge S+lat, i.e. sampled by the core at S+lat+1.
  task automatic xfer(input int c, input int ack_at, input logic [31:0] d);
    exp_t        e;
    int          s;
    int          lat;
    logic [31:0] adr;
    logic [3:0]  a;
    @(negedge clk);
    for (int i = 0; i < 4; i++) DAT_I[i*32 +: 32] = $urandom;
    DAT_I[c*32 +: 32] = d;
    adr = $urandom;
    adr[28:27] = 2'(c);
    ADR_O = adr;
    ch_ack_i = 4'($urandom);
    STB_O = 1'b1;
    corerunning = 1'b1;
    s = cyc + 1;
    if (c < 2) begin
      lat = WS_TAB[c] + 1;
      e.rdee = d;
      e.err = 1'b0;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      lat = ack_at;
      e.rdee = d;
      e.err = 1'b0;
    end else begin
      lat = TMO;
      e.rdee = 32'hFFFF_FFFF;
      e.err = 1'b1;
    end
    e.cyc = s + lat;
    sb_q.push_back(e);
    last_rdee = e.rdee;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy_wait", 32'(busy), 32'd1);
      ADR_O = $urandom;
      a = 4'($urandom);
      if (c >= 2) a[c] = (ack_at != 0 && k >= ack_at) ? 1'b1 : 1'b0;
      ch_ack_i = a;
    end
    @(negedge clk);
    chk("busy_ack", 32'(busy), 32'd1);
    STB_O = 1'b0;
    ch_ack_i = 4'd0;
  endtask

  initial begin
    logic m;
    rst_n = 1'b0;
    DAT_O = 32'h0F0F_3C3C;
    ADR_O = 32'h8000_0006;
    sra_msb = 1'b1;
    DAT_I = '0;
    ch_ack_i = 4'd0;
    sa00 = 1'b0;
    qACK = 1'b0;
    STB_O = 1'b0;
    corerunning = 1'b1;
    stb3 = 1'b0;
    dat3 = 24'd0;
    last_rdee = 32'd0;
    #3;
    chk("rst_ack", 32'(ACK_O), 32'd0);
    chk("rst_err", 32'(ERR_O), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdee", rDee, 32'd0);
    chk("rst_di", Di, di_ref(1'b0, DAT_O, 32'd0, ADR_O, sra_msb));
    chk("rst_rdee3", rdee3, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed transfers
    xfer(1, 0, 32'h1234_5678);
    @(negedge clk);
    DAT_O = 32'hFFFF_0000; ADR_O = 32'h0000_0002; sra_msb = 1'b0; sa00 = 1'b1;
    @(negedge clk);
    chk("di_blend", Di, 32'h1234_0001);
    DAT_O = 32'hDEAD_BEEF; sa00 = 1'b0; qACK = 1'b0; corerunning = 1'b1;
    @(negedge clk);
    chk("di_ebr", Di, 32'hDEAD_BEEF);
    xfer(2, 4, 32'h0000_00A5);
    xfer(3, 0, $urandom);
    xfer(3, TMO, $urandom);
    xfer(3, TMO + 1, $urandom);
    xfer(0, 0, $urandom);
    xfer(2, 1, $urandom);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      xfer($urandom_range(0, 3), $urandom_range(0, TMO + 2), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Di merge under random select inputs while idle
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      DAT_O = $urandom; ADR_O = $urandom; sra_msb = 1'($urandom);
      sa00 = 1'($urandom); qACK = 1'($urandom); corerunning = 1'($urandom);
      m = ~(qACK | sa00 | ~corerunning);
      @(negedge clk);
      chk("di_rand", Di, di_ref(m, DAT_O, last_rdee, ADR_O, sra_msb));
    end
    sa00 = 1'b0; qACK = 1'b0; corerunning = 1'b1;

    // abort by corerunning drop mid-wait: no ACK, rDee held
    xfer(1, 0, 32'hCAFE_F00D);
    @(negedge clk);
    ADR_O = 32'h0000_0000; STB_O = 1'b1; corerunning = 1'b1;
    repeat (4) @(negedge clk);
    corerunning = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      DAT_I = {4{32'($urandom)}};
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rdee", rDee, 32'hCAFE_F00D);
    end
    STB_O = 1'b0; corerunning = 1'b1;

    // reset asserted mid-wait acts before the next edge
    @(negedge clk);
    ADR_O = 32'h0000_0000; STB_O = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(ACK_O), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rdee", rDee, 32'd0);
    STB_O = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdee = 32'd0;

    // 3-channel 8-bit instance: zero-wait capture, abort, bad channel
    @(negedge clk);
    dat3 = 24'($urandom); ADR_O = 32'h0000_0000; stb3 = 1'b1;
    d3 = {24'd0, dat3[7:0]};
    @(negedge clk);
    chk("n3_ws0_early", 32'(ack3), 32'd0);
    @(negedge clk);
    chk("n3_ws0_ack", 32'(ack3), 32'd1);
    chk("n3_ws0_err", 32'(err3), 32'd0);
    chk("n3_ws0_rdee", rdee3, d3);
    stb3 = 1'b0;
    @(negedge clk);
    ADR_O = 32'h0800_0000; stb3 = 1'b1;
    repeat (4) @(negedge clk);
    corerunning = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      dat3 = 24'($urandom);
      chk("n3_abort_ack", 32'(ack3), 32'd0);
      chk("n3_abort_rdee", rdee3, d3);
    end
    stb3 = 1'b0; corerunning = 1'b1;
    @(negedge clk);
    chk("n3_abort_busy", 32'(busy3), 32'd0);
    ADR_O = 32'h1800_0000; stb3 = 1'b1;
    @(negedge clk);
    chk("n3_bad_ack", 32'(ack3), 32'd1);
    chk("n3_bad_err", 32'(err3), 32'd1);
    chk("n3_bad_rdee", rdee3, 32'd0);
    stb3 = 1'b0;
    @(negedge clk);
    chk("n3_bad_pulse", 32'(ack3), 32'd0);

    repeat (3) @(negedge clk);
    chk("missing_ack", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
